// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : sprite_compositor
// Description : Merges player/enemy sprite bits into one RGB565 pixel, latches
//               player/enemy collisions per frame and publishes them at frame
//               boundaries. Optional post-hit player flash is compiled in with
//               SPRITE_COMPOSITOR_FLASH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_compositor #(
    parameter logic [15:0] PLAYER_COLOR = 16'h07FF,
    parameter logic [15:0] ENEMY_COLOR  = 16'h07E0,
    parameter logic [15:0] BG_COLOR     = 16'h0000,
    parameter logic [15:0] HIT_COLOR    = 16'hF800,
    parameter int          FLASH_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        video_on,
    input  logic        player_gfx,
    input  logic [2:0]  enemy_gfx,
    output logic [15:0] rgb_o,
    output logic [2:0]  hit_o,
    output logic        hit_pulse_o,
    output logic        flash_active_o
);

    if (FLASH_FRAMES < 1 || FLASH_FRAMES > 15) begin : g_flash_range_err
        $error("FLASH_FRAMES must be within 1..15");
    end

    logic        r_frame_start_s1;
    logic        r_video_on_s1;
    logic        r_player_s1;
    logic [2:0]  r_enemy_s1;
    logic [2:0]  r_pending;
    logic [2:0]  w_coll;
    logic        w_flash_active;
    logic [15:0] w_player_color;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_start_s1 <= 1'b0;
            r_video_on_s1    <= 1'b0;
            r_player_s1      <= 1'b0;
            r_enemy_s1       <= 3'b000;
        end else begin
            r_frame_start_s1 <= frame_start;
            r_video_on_s1    <= video_on;
            r_player_s1      <= player_gfx;
            r_enemy_s1       <= enemy_gfx;
        end
    end

    // Only player-vs-enemy overlaps count; enemy-vs-enemy is ignored.
    assign w_coll = {3{r_video_on_s1 & r_player_s1}} & r_enemy_s1;

    // The frame_start pixel seeds the new frame's pending set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= 3'b000;
            hit_o       <= 3'b000;
            hit_pulse_o <= 1'b0;
        end else if (r_frame_start_s1) begin
            r_pending   <= w_coll;
            hit_o       <= r_pending;
            hit_pulse_o <= (r_pending != 3'b000);
        end else begin
            r_pending   <= r_pending | w_coll;
            hit_pulse_o <= 1'b0;
        end
    end

`ifdef SPRITE_COMPOSITOR_FLASH_EN
    localparam logic [3:0] c_FLASH_LOAD = 4'(FLASH_FRAMES);

    logic [3:0] r_flash_cnt;

    // A reload on a new hit takes precedence over the per-frame decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flash_cnt <= 4'd0;
        end else if (r_frame_start_s1) begin
            if (r_pending != 3'b000) begin
                r_flash_cnt <= c_FLASH_LOAD;
            end else if (r_flash_cnt != 4'd0) begin
                r_flash_cnt <= r_flash_cnt - 4'd1;
            end
        end
    end

    assign w_flash_active = (r_flash_cnt != 4'd0);
`else
    assign w_flash_active = 1'b0;
`endif

    assign flash_active_o = w_flash_active;
    assign w_player_color = w_flash_active ? HIT_COLOR : PLAYER_COLOR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_o <= 16'h0000;
        end else if (!r_video_on_s1) begin
            rgb_o <= 16'h0000;
        end else if (r_player_s1) begin
            rgb_o <= w_player_color;
        end else if (r_enemy_s1 != 3'b000) begin
            rgb_o <= ENEMY_COLOR;
        end else begin
            rgb_o <= BG_COLOR;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_compositor
// Description : Scoreboard bench for sprite_compositor with FLASH_FRAMES=3;
//               expectations follow SPRITE_COMPOSITOR_FLASH_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;

`ifdef SPRITE_COMPOSITOR_FLASH_EN
    localparam bit c_FL = 1'b1;
`else
    localparam bit c_FL = 1'b0;
`endif
    localparam logic [15:0] c_P = 16'h07FF;
    localparam logic [15:0] c_E = 16'h07E0;
    localparam logic [15:0] c_B = 16'h0000;
    localparam logic [15:0] c_H = c_FL ? 16'hF800 : 16'h07FF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        video_on = 1'b0;
    logic        player_gfx = 1'b0;
    logic [2:0]  enemy_gfx = 3'b000;
    logic [15:0] rgb_o;
    logic [2:0]  hit_o;
    logic        hit_pulse_o;
    logic        flash_active_o;

    sprite_compositor #(
        .PLAYER_COLOR (16'h07FF),
        .ENEMY_COLOR  (16'h07E0),
        .BG_COLOR     (16'h0000),
        .HIT_COLOR    (16'hF800),
        .FLASH_FRAMES (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .video_on       (video_on),
        .player_gfx     (player_gfx),
        .enemy_gfx      (enemy_gfx),
        .rgb_o          (rgb_o),
        .hit_o          (hit_o),
        .hit_pulse_o    (hit_pulse_o),
        .flash_active_o (flash_active_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        int          id;
        logic [15:0] rgb;
        logic [2:0]  hit;
        logic        pulse;
        logic        flash;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_pix = 0;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] cur_hit = 3'b000;
    logic       cur_flash = 1'b0;

    task automatic chk(input string name, input int id, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s pix%0d: got %h expected %h", name, id, got, exp);
        end
    endtask

    // Monitor: every output is due two negedges after its pixel was driven.
    always @(negedge clk) begin
        cyc++;
        while (q.size() > 0 && q[0].t <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.t < cyc) begin
                checks++;
                errors++;
                $display("FAIL sched pix%0d: due %0d seen %0d", e.id, e.t, cyc);
            end else begin
                chk("rgb",   e.id, rgb_o, e.rgb);
                chk("hit",   e.id, {13'd0, hit_o}, {13'd0, e.hit});
                chk("pulse", e.id, {15'd0, hit_pulse_o}, {15'd0, e.pulse});
                chk("flash", e.id, {15'd0, flash_active_o}, {15'd0, e.flash});
            end
        end
    end

    task automatic drive(input logic fs, input logic vo, input logic pl, input logic [2:0] en);
        @(negedge clk);
        #1;
        frame_start = fs;
        video_on    = vo;
        player_gfx  = pl;
        enemy_gfx   = en;
    endtask

    task automatic push(input logic [15:0] rgb, input logic pulse);
        exp_t e;
        e.t = cyc + 2; e.id = n_pix; e.rgb = rgb;
        e.hit = cur_hit; e.pulse = pulse; e.flash = cur_flash;
        q.push_back(e);
        n_pix++;
    endtask

    task automatic pix(input logic vo, input logic pl, input logic [2:0] en, input logic [15:0] rgb);
        drive(1'b0, vo, pl, en);
        push(rgb, 1'b0);
    endtask

    task automatic boundary(input logic pl, input logic [2:0] en, input logic [15:0] rgb,
                            input logic [2:0] new_hit, input logic pulse, input logic new_flash);
        drive(1'b1, 1'b1, pl, en);
        cur_hit   = new_hit;
        cur_flash = new_flash & c_FL;
        push(rgb, pulse);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rgb"},   -1, rgb_o, 16'h0000);
        chk({name, "_hit"},   -1, {13'd0, hit_o}, 16'h0000);
        chk({name, "_pulse"}, -1, {15'd0, hit_pulse_o}, 16'h0000);
        chk({name, "_flash"}, -1, {15'd0, flash_active_o}, 16'h0000);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_zero("init");
        @(negedge clk);
        #1 reset = 1'b0;

        // Colour priority, each pixel checked two cycles later.
        pix(1'b1, 1'b1, 3'b111, c_P);
        pix(1'b1, 1'b0, 3'b010, c_E);
        pix(1'b1, 1'b0, 3'b000, c_B);
        pix(1'b0, 1'b1, 3'b000, 16'h0000);
        pix(1'b1, 1'b1, 3'b000, c_P);

        // Mid-stream reset: pending collisions and pipeline must be dropped.
        drive(1'b0, 1'b1, 1'b1, 3'b001);
        drive(1'b0, 1'b1, 1'b1, 3'b001);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("rst");
        enemy_gfx = 3'b000;
        repeat (2) @(posedge clk);
        #1 chk_zero("rst_hold");
        @(negedge clk);
        #1 reset = 1'b0;

        boundary(1'b0, 3'b000, c_B, 3'b000, 1'b0, 1'b0);
        pix(1'b1, 1'b0, 3'b000, c_B);
        pix(1'b1, 1'b1, 3'b010, c_P);
        pix(1'b1, 1'b1, 3'b010, c_P);
        pix(1'b1, 1'b1, 3'b010, c_P);
        pix(1'b1, 1'b0, 3'b000, c_B);
        boundary(1'b0, 3'b000, c_B, 3'b010, 1'b1, 1'b1);
        pix(1'b1, 1'b1, 3'b000, c_H);
        pix(1'b1, 1'b0, 3'b000, c_B);
        boundary(1'b0, 3'b000, c_B, 3'b000, 1'b0, 1'b1);
        pix(1'b1, 1'b1, 3'b000, c_H);
        boundary(1'b0, 3'b000, c_B, 3'b000, 1'b0, 1'b1);
        pix(1'b1, 1'b1, 3'b000, c_H);
        boundary(1'b0, 3'b000, c_B, 3'b000, 1'b0, 1'b0);
        pix(1'b1, 1'b1, 3'b000, c_P);

        // Collision on the frame_start pixel belongs to the new frame.
        boundary(1'b1, 3'b100, c_P, 3'b000, 1'b0, 1'b0);
        pix(1'b1, 1'b0, 3'b000, c_B);
        boundary(1'b0, 3'b000, c_B, 3'b100, 1'b1, 1'b1);

        // Hit during flash reloads; back-to-back boundaries count down.
        pix(1'b1, 1'b1, 3'b001, c_H);
        boundary(1'b0, 3'b000, c_B, 3'b001, 1'b1, 1'b1);
        boundary(1'b0, 3'b000, c_B, 3'b000, 1'b0, 1'b1);
        boundary(1'b0, 3'b000, c_B, 3'b000, 1'b0, 1'b1);
        boundary(1'b0, 3'b000, c_B, 3'b000, 1'b0, 1'b0);
        pix(1'b1, 1'b1, 3'b000, c_P);

        // Last active pixel collides, then blanking before the boundary.
        pix(1'b1, 1'b1, 3'b010, c_P);
        pix(1'b0, 1'b0, 3'b000, 16'h0000);
        boundary(1'b0, 3'b000, c_B, 3'b010, 1'b1, 1'b1);
        pix(1'b1, 1'b1, 3'b000, c_H);

        // Blanked overlap and enemy-only overlap are not collisions.
        pix(1'b0, 1'b1, 3'b111, 16'h0000);
        pix(1'b1, 1'b0, 3'b011, c_E);
        boundary(1'b0, 3'b000, c_B, 3'b000, 1'b0, 1'b1);
        pix(1'b1, 1'b0, 3'b000, c_B);

        drive(1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
